// File: rtl/tmr_lif_core_p.sv
// Triple-modular-redundant leaky integrate-and-fire neuron with majority voting,
// per-replica mismatch tracking, saturating fault counters and optional scrubbing.
module tmr_lif_core_p #(
  parameter int              WIDTH      = 16,
  parameter int              FRAC       = 8,
  parameter logic [WIDTH-1:0] THRESH    = 16'h3200,
  parameter logic [WIDTH-1:0] V_RESET   = 16'h0000,
  parameter int              LEAK_SHIFT = 4,
  parameter int              REFRAC     = 3,
  parameter int              SCRUB      = 1,
  parameter int              CNT_W      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] I_in1,
  input  logic signed [WIDTH-1:0] I_in2,
  input  logic signed [WIDTH-1:0] I_in3,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] V_out,
  output logic                    spike,
  output logic [2:0]              mismatch,
  output logic                    uncorr,
  output logic [CNT_W-1:0]        fault_cnt1,
  output logic [CNT_W-1:0]        fault_cnt2,
  output logic [CNT_W-1:0]        fault_cnt3
);

  localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam logic signed [WIDTH+1:0] SMAX = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH+1:0] SMIN = {3'b111, {(WIDTH-1){1'b0}}};

  // FRAC only documents the Q format; it must still describe a legal split.
  if (FRAC < 0 || FRAC >= WIDTH) begin : g_bad_frac
    $error("tmr_lif_core_p: FRAC must lie in [0, WIDTH)");
  end

  function automatic logic signed [WIDTH-1:0] sat_w(input logic signed [WIDTH+1:0] x);
    if (x > SMAX) return SMAX[WIDTH-1:0];
    if (x < SMIN) return SMIN[WIDTH-1:0];
    return x[WIDTH-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  logic signed [WIDTH-1:0] i_p0    [3];
  logic signed [WIDTH-1:0] v_q     [3];
  logic [RW-1:0]           rc_q    [3];
  logic [CNT_W-1:0]        fcnt    [3];
  logic signed [WIDTH-1:0] leak_p0 [3];
  logic signed [WIDTH+1:0] sum_p0  [3];
  logic signed [WIDTH-1:0] sat_p0  [3];
  logic signed [WIDTH-1:0] v_p0    [3];
  logic [RW-1:0]           rc_p0   [3];
  logic [2:0]              s_p0;
  logic signed [WIDTH-1:0] vv_p0;
  logic [RW-1:0]           rv_p0;
  logic                    uv_p0, ur_p0, unc_p0, spk_p0;
  logic [2:0]              mm_p0;

  assign i_p0[0]    = I_in1;
  assign i_p0[1]    = I_in2;
  assign i_p0[2]    = I_in3;
  assign fault_cnt1 = fcnt[0];
  assign fault_cnt2 = fcnt[1];
  assign fault_cnt3 = fcnt[2];

  // Stage p0: per-replica next state, then vote on the next-state values
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      leak_p0[k] = v_q[k] >>> LEAK_SHIFT;
      sum_p0[k]  = {{2{v_q[k][WIDTH-1]}}, v_q[k]}
                 - {{2{leak_p0[k][WIDTH-1]}}, leak_p0[k]}
                 + {{2{i_p0[k][WIDTH-1]}}, i_p0[k]};
      sat_p0[k]  = sat_w(sum_p0[k]);
      s_p0[k]    = 1'b0;
      v_p0[k]    = sat_p0[k];
      rc_p0[k]   = '0;
      if (rc_q[k] != '0) begin
        v_p0[k]  = V_RESET;
        rc_p0[k] = rc_q[k] - RW'(1);
      end else if (sat_p0[k] >= $signed(THRESH)) begin
        s_p0[k]  = 1'b1;
        v_p0[k]  = V_RESET;
        rc_p0[k] = RW'(REFRAC);
      end
    end

    vv_p0 = v_p0[1];
    uv_p0 = 1'b0;
    if (v_p0[0] == v_p0[1] || v_p0[0] == v_p0[2]) vv_p0 = v_p0[0];
    else if (v_p0[1] != v_p0[2])                   uv_p0 = 1'b1;

    rv_p0 = rc_p0[1];
    ur_p0 = 1'b0;
    if (rc_p0[0] == rc_p0[1] || rc_p0[0] == rc_p0[2]) rv_p0 = rc_p0[0];
    else if (rc_p0[1] != rc_p0[2])                     ur_p0 = 1'b1;

    unc_p0 = uv_p0 | ur_p0;
    spk_p0 = (s_p0[0] & s_p0[1]) | (s_p0[0] & s_p0[2]) | (s_p0[1] & s_p0[2]);
    for (int k = 0; k < 3; k++)
      mm_p0[k] = (v_p0[k] != vv_p0) | (rc_p0[k] != rv_p0);
  end

  // Stage p1: replica state, voted outputs and fault counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        v_q[k]  <= V_RESET;
        rc_q[k] <= '0;
        fcnt[k] <= '0;
      end
      out_valid <= 1'b0;
      V_out     <= V_RESET;
      spike     <= 1'b0;
      mismatch  <= '0;
      uncorr    <= 1'b0;
    end else begin
      out_valid <= in_valid;
      spike     <= in_valid & spk_p0;
      if (in_valid) begin
        for (int k = 0; k < 3; k++) begin
          // With no majority there is nothing trustworthy to scrub with.
          if (SCRUB != 0 && !unc_p0) begin
            v_q[k]  <= vv_p0;
            rc_q[k] <= rv_p0;
          end else begin
            v_q[k]  <= v_p0[k];
            rc_q[k] <= rc_p0[k];
          end
          if (mm_p0[k]) fcnt[k] <= sat_inc(fcnt[k]);
        end
        V_out    <= vv_p0;
        mismatch <= mm_p0;
        uncorr   <= unc_p0;
      end
    end
  end

endmodule

// File: tb/tb_tmr_lif_core_p.sv
// Scoreboard bench for tmr_lif_core_p: directed steps push hand-computed results,
// per-instance monitors pop and compare whenever out_valid is seen.
module tb_tmr_lif_core_p;

  typedef struct {
    logic [15:0] v;
    logic        spk;
    logic [2:0]  mm;
    logic        unc;
    logic [7:0]  c1, c2, c3;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0, in_valid_s = 1'b0;
  logic [15:0] i1 = '0, i2 = '0, i3 = '0;
  logic [15:0] j1 = '0, j2 = '0, j3 = '0;
  logic        out_valid, spike, uncorr;
  logic [15:0] v_out;
  logic [2:0]  mismatch;
  logic [7:0]  c1, c2, c3;
  logic        out_valid_s, spike_s, uncorr_s;
  logic [15:0] v_out_s;
  logic [2:0]  mismatch_s;
  logic [7:0]  c1_s, c2_s, c3_s;

  exp_t q[$];
  exp_t qs[$];
  exp_t em, es;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  tmr_lif_core_p u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .I_in1(i1), .I_in2(i2), .I_in3(i3),
    .out_valid(out_valid), .V_out(v_out), .spike(spike),
    .mismatch(mismatch), .uncorr(uncorr),
    .fault_cnt1(c1), .fault_cnt2(c2), .fault_cnt3(c3)
  );

  tmr_lif_core_p #(.THRESH(16'h7FFF)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid_s),
    .I_in1(j1), .I_in2(j2), .I_in3(j3),
    .out_valid(out_valid_s), .V_out(v_out_s), .spike(spike_s),
    .mismatch(mismatch_s), .uncorr(uncorr_s),
    .fault_cnt1(c1_s), .fault_cnt2(c2_s), .fault_cnt3(c3_s)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Issue one timestep on the main (sat=0) or high-threshold (sat=1) instance.
  task automatic step(input bit sat, input logic [15:0] a, b, c,
                      input logic [15:0] ev, input logic es_, input logic [2:0] emm,
                      input logic eu, input logic [7:0] e1, e2, e3);
    exp_t e;
    e.v = ev; e.spk = es_; e.mm = emm; e.unc = eu; e.c1 = e1; e.c2 = e2; e.c3 = e3;
    @(negedge clk);
    if (sat) begin
      in_valid_s = 1'b1; j1 = a; j2 = b; j3 = c;
      qs.push_back(e);
    end else begin
      in_valid = 1'b1; i1 = a; i2 = b; i3 = c;
      q.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid   = 1'b0;
    in_valid_s = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0; in_valid_s = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected out_valid: got 1, expected 0 (t=%0t)", $time);
      end else begin
        em = q.pop_front();
        chk("V_out", 32'(v_out), 32'(em.v));
        chk("spike", 32'(spike), 32'(em.spk));
        chk("mismatch", 32'(mismatch), 32'(em.mm));
        chk("uncorr", 32'(uncorr), 32'(em.unc));
        chk("fault_cnt1", 32'(c1), 32'(em.c1));
        chk("fault_cnt2", 32'(c2), 32'(em.c2));
        chk("fault_cnt3", 32'(c3), 32'(em.c3));
      end
    end
  end

  always @(negedge clk) begin
    if (out_valid_s === 1'b1) begin
      if (qs.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected out_valid (sat): got 1, expected 0 (t=%0t)", $time);
      end else begin
        es = qs.pop_front();
        chk("sat V_out", 32'(v_out_s), 32'(es.v));
        chk("sat spike", 32'(spike_s), 32'(es.spk));
        chk("sat mismatch", 32'(mismatch_s), 32'(es.mm));
        chk("sat uncorr", 32'(uncorr_s), 32'(es.unc));
        chk("sat fault_cnt3", 32'(c3_s), 32'(es.c3));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    chk("reset out_valid", 32'(out_valid), 32'h0);
    chk("reset V_out", 32'(v_out), 32'h0);
    chk("reset spike", 32'(spike), 32'h0);
    chk("reset mismatch", 32'(mismatch), 32'h0);
    chk("reset uncorr", 32'(uncorr), 32'h0);
    chk("reset fault_cnt1", 32'(c1), 32'h0);
    rst = 1'b1;

    // Integration up to a spike, then the refractory window
    step(0, 16'h1000, 16'h1000, 16'h1000, 16'h1000, 0, 3'b000, 0, 0, 0, 0);
    step(0, 16'h1000, 16'h1000, 16'h1000, 16'h1F00, 0, 3'b000, 0, 0, 0, 0);
    step(0, 16'h1000, 16'h1000, 16'h1000, 16'h2D10, 0, 3'b000, 0, 0, 0, 0);
    step(0, 16'h1000, 16'h1000, 16'h1000, 16'h0000, 1, 3'b000, 0, 0, 0, 0);
    for (int n = 0; n < 3; n++)
      step(0, 16'h1000, 16'h1000, 16'h1000, 16'h0000, 0, 3'b000, 0, 0, 0, 0);
    step(0, 16'h1000, 16'h1000, 16'h1000, 16'h1000, 0, 3'b000, 0, 0, 0, 0);
    idle();
    @(negedge clk);
    chk("idle out_valid", 32'(out_valid), 32'h0);
    chk("idle V_out hold", 32'(v_out), 32'h1000);
    chk("idle spike", 32'(spike), 32'h0);

    // Single upset on replica 1, scrubbed on the same edge
    do_reset();
    step(0, 16'h1200, 16'h1000, 16'h1000, 16'h1000, 0, 3'b001, 0, 1, 0, 0);
    idle();
    @(negedge clk);
    chk("hold mismatch", 32'(mismatch), 32'h1);
    chk("hold V_out", 32'(v_out), 32'h1000);
    chk("hold fault_cnt1", 32'(c1), 32'h1);
    step(0, 16'h1000, 16'h1000, 16'h1000, 16'h1F00, 0, 3'b000, 0, 1, 0, 0);
    idle();

    // Triple disagreement: V_2 wins, no scrub, disagreement persists
    do_reset();
    step(0, 16'h1000, 16'h1200, 16'h1400, 16'h1200, 0, 3'b101, 1, 1, 0, 1);
    step(0, 16'h0000, 16'h0000, 16'h0000, 16'h10E0, 0, 3'b101, 1, 2, 0, 2);
    idle();

    // Negative saturation
    do_reset();
    step(0, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 0, 3'b000, 0, 0, 0, 0);
    step(0, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 0, 3'b000, 0, 0, 0, 0);
    idle();

    // Positive saturation happens before the threshold compare
    do_reset();
    step(0, 16'h3100, 16'h3100, 16'h3100, 16'h3100, 0, 3'b000, 0, 0, 0, 0);
    step(0, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000, 1, 3'b000, 0, 0, 0, 0);
    idle();

    // Threshold boundary: just below, then exactly at
    do_reset();
    step(0, 16'h31FF, 16'h31FF, 16'h31FF, 16'h31FF, 0, 3'b000, 0, 0, 0, 0);
    idle();
    do_reset();
    step(0, 16'h3200, 16'h3200, 16'h3200, 16'h0000, 1, 3'b000, 0, 0, 0, 0);
    idle();

    // THRESH=7FFF instance: saturated sum equals threshold and fires
    do_reset();
    step(1, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 0, 3'b000, 0, 0, 0, 0);
    step(1, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000, 1, 3'b000, 0, 0, 0, 0);
    idle();

    // Persistent fault on replica 3: counter saturates without wrapping
    do_reset();
    for (int n = 1; n <= 300; n++)
      step(0, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 0, 3'b100, 0, 0, 0,
           (n >= 255) ? 8'hFF : 8'(n));
    idle();

    // Asynchronous reset between edges while a step is being offered
    @(negedge clk);
    in_valid = 1'b1; i1 = 16'h1000; i2 = 16'h1000; i3 = 16'h1000;
    #2 rst = 1'b0;
    #1;
    chk("async out_valid", 32'(out_valid), 32'h0);
    chk("async mismatch", 32'(mismatch), 32'h0);
    chk("async fault_cnt3", 32'(c3), 32'h0);
    chk("async V_out", 32'(v_out), 32'h0);
    @(negedge clk);
    chk("async no pulse", 32'(out_valid), 32'h0);
    in_valid = 1'b0;
    rst = 1'b1;

    repeat (3) @(negedge clk);
    chk("main queue drained", 32'(q.size()), 32'h0);
    chk("sat queue drained", 32'(qs.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
